// File: rtl/dmem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if_pkg
//  Brief    : Shared size codes, FSM state encoding and defaults for dmem_if.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam int c_timeout_cyc_dflt = 255;

endpackage : dmem_if_pkg
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_align
//  Brief    : Store byte-enable / lane replication and load lane select / extend.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_align
    import dmem_if_pkg::*;
(
    input  logic [1:0]  i_st_addr_lo,
    input  logic [1:0]  i_st_size,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_lanes,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_uns,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Reserved size code 2'b11 falls into the word branch on both sides.
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_lanes = i_st_wdata;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_lanes = {4{i_st_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_lanes = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_ld_word[7:0];
        case (i_ld_addr_lo)
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            2'd3:    w_byte = i_ld_word[31:24];
            default: w_byte = i_ld_word[7:0];
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        o_ld_data = i_ld_word;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{~i_ld_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{~i_ld_uns & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule : dmem_align
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if
//  Brief    : Core-to-data-memory req/ack bridge with alignment, stall and errors.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_if
    import dmem_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_timeout_cyc_dflt
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        load_uns,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_uns;

    logic        w_access;
    logic        w_misalign;
    logic        w_limit;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_lanes;
    logic [31:0] w_ld_data;

    assign w_access   = mem_read | mem_write;
    assign w_misalign = ((size == SZ_HALF) & addr[0]) |
                        ((size[1] == 1'b1) & (addr[1:0] != 2'b00));
    assign w_limit    = (r_cnt == c_cnt_last);

    dmem_align u_align (
        .i_st_addr_lo (addr[1:0]),
        .i_st_size    (size),
        .i_st_wdata   (wdata),
        .o_st_be      (w_st_be),
        .o_st_lanes   (w_st_lanes),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_size    (r_size),
        .i_ld_uns     (r_uns),
        .i_ld_word    (bus_rdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ack in the same cycle as the timeout limit completes normally.
    always_comb begin
        w_state_nxt = c_st_idle;
        case (r_state)
            c_st_idle: begin
                if (w_access) begin
                    w_state_nxt = w_misalign ? c_st_resp : c_st_req;
                end
            end
            c_st_req: begin
                w_state_nxt = (bus_ack | w_limit) ? c_st_resp : c_st_req;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        stall   = ((r_state == c_st_idle) & w_access) | (r_state == c_st_req);
        bus_req = (r_state == c_st_req);
        mem_err = (r_state == c_st_resp) & r_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 8'd0;
            r_err       <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_addr_lo   <= 2'd0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cnt <= 8'd0;
                    if (w_access) begin
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_err       <= 1'b0;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_be    <= w_st_be;
                            r_bus_wdata <= w_st_lanes;
                            r_addr_lo   <= addr[1:0];
                            r_size      <= size;
                            r_uns       <= load_uns;
                        end
                    end
                end
                c_st_req: begin
                    if (bus_ack) begin
                        r_cnt <= 8'd0;
                        if (!r_bus_we) begin
                            r_rdata <= w_ld_data;
                        end
                    end else if (w_limit) begin
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule : dmem_if
`default_nettype wire

// File: tb/tb_dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_if
//  Brief    : Directed and randomized self-checking bench for dmem_if.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_if;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, load_uns, bus_ack;
    logic [31:0] addr, wdata, bus_rdata;
    logic [1:0]  size;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        stall, mem_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;

    // Observations gathered by run_access.
    int          n_stall, n_req, n_err;
    logic        unstable, timed_out;
    logic        s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic [31:0] exp_prev;

    dmem_if #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .size      (size),
        .load_uns  (load_uns),
        .rdata     (rdata),
        .stall     (stall),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Reference: load result as shift/mask of the word, extension by arithmetic.
    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] lo, logic [1:0] sz, logic uns);
        logic [31:0] sh;
        sh = w >> (8 * lo);
        if (sz == 2'b00) return (!uns && sh[7])  ? ((sh & 32'hFF)   | 32'hFFFF_FF00) : (sh & 32'hFF);
        if (sz == 2'b01) return (!uns && sh[15]) ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
        return w;
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] lo, logic [1:0] sz);
        if (sz == 2'b00) return 4'b0001 << lo;
        if (sz == 2'b01) return 4'b0011 << lo;
        return 4'b1111;
    endfunction

    function automatic logic ref_misalign(logic [1:0] lo, logic [1:0] sz);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return lo[0];
        return lo != 2'b00;
    endfunction

    // Drives one access from IDLE and plays the memory; ack_after > TO means no ack.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                              input int ack_after, input logic [31:0] rword);
        logic done;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; size = sz; load_uns = uns;
        n_stall = 0; n_req = 0; n_err = 0; unstable = 0; done = 0;
        s_we = 0; s_addr = 0; s_be = 0; s_wdata = 0; s_rdata = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stall)   n_stall++;
            if (mem_err) n_err++;
            if (bus_req) begin
                if (n_req == 0) begin
                    s_we = bus_we; s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata;
                end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {s_we, s_addr, s_be, s_wdata}) begin
                    unstable = 1;
                end
                n_req++;
                if (n_req == ack_after) begin
                    bus_ack = 1'b1;
                    bus_rdata = rword;
                end
            end
            if (!stall) begin
                done = 1;
                s_rdata = rdata;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        timed_out = !done;
        mem_read = 0; mem_write = 0;
    endtask

    task automatic test_reset();
        rst = 0; mem_read = 0; mem_write = 0; addr = 0; wdata = 0; size = 0;
        load_uns = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus_req !== 1'b0)  begin bad++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
        total++; if (bus_we !== 1'b0)   begin bad++; $display("FAIL reset_bus_we got=%b exp=0", bus_we); end
        total++; if (bus_addr !== 32'd0) begin bad++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
        total++; if (bus_be !== 4'd0)   begin bad++; $display("FAIL reset_bus_be got=%b exp=0", bus_be); end
        total++; if (bus_wdata !== 32'd0) begin bad++; $display("FAIL reset_bus_wdata got=%h exp=0", bus_wdata); end
        total++; if (rdata !== 32'd0)   begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if ({stall, mem_err} !== 2'b00) begin bad++; $display("FAIL reset_stall_err got=%b exp=00", {stall, mem_err}); end
        rst = 1;
        @(posedge clk); #1;
        exp_prev = 32'd0;
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 3, 32'h0);
        total++; if (s_be !== 4'b1111)        begin bad++; $display("FAIL sw_be got=%b exp=1111", s_be); end
        total++; if (s_addr !== 32'h10)       begin bad++; $display("FAIL sw_addr got=%h exp=10", s_addr); end
        total++; if (s_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", s_wdata); end
        total++; if (s_we !== 1'b1)           begin bad++; $display("FAIL sw_we got=%b exp=1", s_we); end
        total++; if (n_stall != 4)            begin bad++; $display("FAIL sw_stall_cycles got=%0d exp=4", n_stall); end
        total++; if (n_err != 0)              begin bad++; $display("FAIL sw_err got=%0d exp=0", n_err); end
        total++; if (s_rdata !== exp_prev)    begin bad++; $display("FAIL sw_rdata_kept got=%h exp=%h", s_rdata, exp_prev); end
    endtask

    task automatic test_store_byte();
        run_access(1'b0, 1'b1, 32'h13, 32'h000000A5, 2'b00, 1'b0, 2, 32'h0);
        total++; if (s_be !== 4'b1000)        begin bad++; $display("FAIL sb_be got=%b exp=1000", s_be); end
        total++; if (s_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", s_wdata); end
        total++; if (s_addr !== 32'h10)       begin bad++; $display("FAIL sb_addr got=%h exp=10", s_addr); end
    endtask

    task automatic test_load_byte();
        run_access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 1, 32'h12348056);
        total++; if (s_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffff80", s_rdata); end
        total++; if (s_be !== 4'b0010 || s_we !== 1'b0) begin bad++; $display("FAIL lb_be_we got=%b/%b exp=0010/0", s_be, s_we); end
        run_access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 2, 32'h12348056);
        total++; if (s_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_unsigned got=%h exp=00000080", s_rdata); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 100, 32'h0);
        total++; if (n_req != TO)          begin bad++; $display("FAIL to_req_cycles got=%0d exp=%0d", n_req, TO); end
        total++; if (s_rdata !== 32'd0)    begin bad++; $display("FAIL to_rdata got=%h exp=0", s_rdata); end
        total++; if (n_err != 1)           begin bad++; $display("FAIL to_err_pulses got=%0d exp=1", n_err); end
        total++; if (n_stall != TO + 1)    begin bad++; $display("FAIL to_stall got=%0d exp=%0d", n_stall, TO + 1); end
        total++; if (timed_out)            begin bad++; $display("FAIL to_no_resp got=1 exp=0"); end
    endtask

    task automatic test_load_half();
        run_access(1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 2, 32'h8001FFFF);
        total++; if (s_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_signed got=%h exp=ffff8001", s_rdata); end
        total++; if (s_be !== 4'b1100)         begin bad++; $display("FAIL lh_be got=%b exp=1100", s_be); end
        run_access(1'b1, 1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 1, 32'h55555555);
        total++; if (n_req != 0)            begin bad++; $display("FAIL lw_mis_req got=%0d exp=0", n_req); end
        total++; if (n_err != 1)            begin bad++; $display("FAIL lw_mis_err got=%0d exp=1", n_err); end
        total++; if (n_stall != 1)          begin bad++; $display("FAIL lw_mis_stall got=%0d exp=1", n_stall); end
        total++; if (s_rdata !== 32'd0)     begin bad++; $display("FAIL lw_mis_rdata got=%h exp=0", s_rdata); end
    endtask

    task automatic test_reset_in_req();
        logic seen;
        run_access(1'b1, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 1, 32'hCAFEF00D);
        total++; if (s_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL pre_rst_lw got=%h exp=cafef00d", s_rdata); end
        mem_read = 1; addr = 32'h80; size = 2'b10;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus_req;
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_req_never_req got=0 exp=1"); end
        rst = 0; mem_read = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        total++; if ({bus_req, stall, mem_err} !== 3'b000) begin bad++; $display("FAIL rst_req_abort got=%b exp=000", {bus_req, stall, mem_err}); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_req_rdata got=%h exp=0", rdata); end
        bus_ack = 1; bus_rdata = 32'h13572468;
        @(posedge clk); #1;
        bus_ack = 0;
        @(negedge clk);
        total++; if ({bus_req, stall, mem_err} !== 3'b000 || rdata !== 32'd0)
            begin bad++; $display("FAIL late_ack got=%b/%h exp=000/0", {bus_req, stall, mem_err}, rdata); end
        @(posedge clk); #1;
        exp_prev = 32'd0;
    endtask

    task automatic test_random();
        logic        rd, wr, uns, mis, to;
        logic [1:0]  sz, lo;
        logic [31:0] a, wd, rw, e_rdata;
        int          ack_n, e_req;
        for (int it = 0; it < 40; it++) begin
            {wr, rd} = 2'($urandom_range(1, 3));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = (sz == 2'b00) ? a[1:0] : (sz == 2'b01 ? {a[1], 1'b0} : 2'b00);
            wd = $urandom; rw = $urandom; uns = 1'($urandom_range(0, 1));
            ack_n = $urandom_range(1, TO + 2);
            lo  = a[1:0];
            mis = ref_misalign(lo, sz);
            to  = !mis && (ack_n > TO);
            e_req = mis ? 0 : (to ? TO : ack_n);
            e_rdata = (mis || to) ? 32'd0 : (wr ? exp_prev : ref_load(rw, lo, sz, uns));
            run_access(rd, wr, a, wd, sz, uns, ack_n, rw);
            total++; if (n_req != e_req) begin bad++; $display("FAIL rnd%0d_req got=%0d exp=%0d", it, n_req, e_req); end
            total++; if (n_stall != e_req + 1) begin bad++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", it, n_stall, e_req + 1); end
            total++; if (n_err != ((mis || to) ? 1 : 0)) begin bad++; $display("FAIL rnd%0d_err got=%0d exp=%0d", it, n_err, (mis || to) ? 1 : 0); end
            total++; if (s_rdata !== e_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", it, s_rdata, e_rdata); end
            if (!mis) begin
                total++;
                if (s_we !== wr || s_addr !== {a[31:2], 2'b00} || s_be !== ref_be(lo, sz) || unstable) begin
                    bad++;
                    $display("FAIL rnd%0d_bus got=%b/%h/%b/%b exp=%b/%h/%b/0", it, s_we, s_addr, s_be, unstable,
                             wr, {a[31:2], 2'b00}, ref_be(lo, sz));
                end
                if (wr) begin
                    total++;
                    if (sz == 2'b00 && s_wdata !== {4{wd[7:0]}} || sz == 2'b01 && s_wdata !== {2{wd[15:0]}} ||
                        sz[1] && s_wdata !== wd) begin
                        bad++; $display("FAIL rnd%0d_wdata got=%h src=%h size=%b", it, s_wdata, wd, sz);
                    end
                end
            end
            exp_prev = e_rdata;
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_timeout();
        test_load_half();
        test_reset_in_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_if
`default_nettype wire
